// File: rtl/lcd_char_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_char_ctrl
//
// LCD-side responder for the character-write handshake. Drives an
// HD44780-compatible display over its 8-bit, write-only bus.
//
// Operation:
//    - After reset it runs the power-up init sequence.
//    - It then writes one ASCII character per request.
//    - It tracks the cursor column so text wraps from line 1 to line 2
//      and back again.
//
// Ports:
//    clkLCD      in   1  system clock
//    resetLCDn   in   1  asynchronous, active-low reset
//    data        in   8  ASCII character, sampled with writeStart
//    writeStart  in   1  1-cycle request: write data at the cursor
//    clearStart  in   1  1-cycle request: clear display, home cursor
//    initDone    out  1  high once init is complete, held until reset
//    writeDone   out  1  1-cycle pulse when a character write completes
//    clearDone   out  1  1-cycle pulse when a clear completes
//    lcd_e       out  1  LCD enable strobe
//    lcd_rs      out  1  LCD register select (0 command, 1 data)
//    lcd_rw      out  1  LCD read/write, always 0
//    lcd_db      out  8  LCD data bus
// ---------------------------------------------------------------------------
module lcd_char_ctrl #(
   parameter int POWERUP_CYC  = 20000,
   parameter int EN_HIGH_CYC  = 12,
   parameter int CMD_WAIT_CYC = 2500,
   parameter int CLR_WAIT_CYC = 100000
) (
   input  logic       clkLCD,
   input  logic       resetLCDn,
   input  logic [7:0] data,
   input  logic       writeStart,
   input  logic       clearStart,
   output logic       initDone,
   output logic       writeDone,
   output logic       clearDone,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_db
);

   // One counter serves every wait. It is sized to the longest wait so
   // that it never wraps in the middle of a wait.
   localparam int MAX_AB  = (POWERUP_CYC > EN_HIGH_CYC) ? POWERUP_CYC : EN_HIGH_CYC;
   localparam int MAX_CD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);

   typedef enum logic [2:0] {
      PWR_WAIT,
      SETUP,
      EN_HI,
      WAIT,
      READY
   } state_t;

   // The operation occupying the bus decides what follows its WAIT phase.
   typedef enum logic [1:0] {
      OP_INIT,
      OP_ADDR,
      OP_CHAR,
      OP_CLR
   } op_t;

   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       initIdx_q, initIdx_d;
   logic [4:0]       col_q, col_d;
   logic [7:0]       char_q, char_d;
   logic             rs_q, rs_d;
   logic [7:0]       db_q, db_d;
   logic             e_q, e_d;
   logic             initDone_q, initDone_d;
   logic             writeDone_q, writeDone_d;
   logic             clearDone_q, clearDone_d;
   logic             waitLast;

   // Init command table, issued in order with rs=0:
   // function set 8-bit/2-line, again, display on, clear, entry mode.
   function automatic logic [7:0] initCmd(input logic [2:0] idx);
      case (idx)
         3'd0:    initCmd = 8'h38;
         3'd1:    initCmd = 8'h38;
         3'd2:    initCmd = 8'h0C;
         3'd3:    initCmd = 8'h01;
         default: initCmd = 8'h06;
      endcase
   endfunction

   // The clear command needs the long settle time. A data byte of 0x01
   // (rs=1) is an ordinary write and keeps the short wait.
   always_comb begin
      waitLast = 1'b0;
      if (!rs_q && db_q == 8'h01) begin
         waitLast = (cnt_q == CLR_LAST);
      end else begin
         waitLast = (cnt_q == CMD_LAST);
      end
   end

   // All state and all outputs are registered, so the bus pins are
   // glitch-free. Reset aborts any transfer and restarts the power-up wait.
   always_ff @(posedge clkLCD or negedge resetLCDn) begin
      if (!resetLCDn) begin
         state_q     <= PWR_WAIT;
         op_q        <= OP_INIT;
         cnt_q       <= '0;
         initIdx_q   <= '0;
         col_q       <= '0;
         char_q      <= '0;
         rs_q        <= 1'b0;
         db_q        <= '0;
         e_q         <= 1'b0;
         initDone_q  <= 1'b0;
         writeDone_q <= 1'b0;
         clearDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         initIdx_q   <= initIdx_d;
         col_q       <= col_d;
         char_q      <= char_d;
         rs_q        <= rs_d;
         db_q        <= db_d;
         e_q         <= e_d;
         initDone_q  <= initDone_d;
         writeDone_q <= writeDone_d;
         clearDone_q <= clearDone_d;
      end
   end

   // Next-state logic.
   //
   // Every bus transfer walks SETUP -> EN_HI -> WAIT. A transfer is
   // "issued" by loading rs/db and entering SETUP, so the pins are valid
   // one full cycle before lcd_e rises. Whatever comes next is decided
   // in the final WAIT cycle, which lets an address command and its
   // character run back to back.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      initIdx_d   = initIdx_q;
      col_d       = col_q;
      char_d      = char_q;
      rs_d        = rs_q;
      db_d        = db_q;
      e_d         = e_q;
      initDone_d  = initDone_q;
      writeDone_d = 1'b0;
      clearDone_d = 1'b0;

      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == PWR_LAST) begin
               cnt_d     = '0;
               op_d      = OP_INIT;
               initIdx_d = 3'd0;
               rs_d      = 1'b0;
               db_d      = initCmd(3'd0);
               state_d   = SETUP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         SETUP: begin
            cnt_d   = '0;
            e_d     = 1'b1;
            state_d = EN_HI;
         end

         EN_HI: begin
            if (cnt_q == EN_LAST) begin
               cnt_d   = '0;
               e_d     = 1'b0;
               state_d = WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         WAIT: begin
            if (waitLast) begin
               cnt_d = '0;
               case (op_q)
                  OP_INIT: begin
                     if (initIdx_q == 3'd4) begin
                        initDone_d = 1'b1;
                        state_d    = READY;
                     end else begin
                        initIdx_d = initIdx_q + 3'd1;
                        db_d      = initCmd(initIdx_q + 3'd1);
                        state_d   = SETUP;
                     end
                  end
                  OP_ADDR: begin
                     op_d    = OP_CHAR;
                     rs_d    = 1'b1;
                     db_d    = char_q;
                     state_d = SETUP;
                  end
                  OP_CHAR: begin
                     col_d       = col_q + 5'd1;
                     writeDone_d = 1'b1;
                     state_d     = READY;
                  end
                  default: begin
                     col_d       = 5'd0;
                     clearDone_d = 1'b1;
                     state_d     = READY;
                  end
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         READY: begin
            // A write wins over a simultaneous clear.
            // Column 0 (line 1) and column 16 (line 2) need the DDRAM
            // address set explicitly before the character goes out.
            if (writeStart) begin
               char_d  = data;
               cnt_d   = '0;
               state_d = SETUP;
               if (col_q == 5'd16) begin
                  op_d = OP_ADDR;
                  rs_d = 1'b0;
                  db_d = 8'hC0;
               end else if (col_q == 5'd0) begin
                  op_d = OP_ADDR;
                  rs_d = 1'b0;
                  db_d = 8'h80;
               end else begin
                  op_d = OP_CHAR;
                  rs_d = 1'b1;
                  db_d = data;
               end
            end else if (clearStart) begin
               cnt_d   = '0;
               op_d    = OP_CLR;
               rs_d    = 1'b0;
               db_d    = 8'h01;
               state_d = SETUP;
            end
         end

         default: begin
            state_d = PWR_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   assign initDone  = initDone_q;
   assign writeDone = writeDone_q;
   assign clearDone = clearDone_q;
   assign lcd_e     = e_q;
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_db    = db_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_char_ctrl
//
// Scoreboard bench for lcd_char_ctrl using small timing parameters.
//
// Stimulus side:
//    - Issues requests.
//    - Pushes the expected LCD bus writes into one queue.
//    - Pushes the expected done events (with their cycle) into another.
//
// Monitor side:
//    - Watches the pins on the falling clock edge.
//    - Pops an entry whenever the DUT shows a bus write or a done pulse.
// ---------------------------------------------------------------------------
module tb_lcd_char_ctrl;

   localparam int POWERUP  = 20;
   localparam int EN_HIGH  = 3;
   localparam int CMD_WAIT = 5;
   localparam int CLR_WAIT = 10;

   localparam int LAT      = 2 + EN_HIGH + CMD_WAIT;
   localparam int LAT_ADDR = 2 * LAT - 1;
   localparam int LAT_CLR  = 2 + EN_HIGH + CLR_WAIT;
   localparam int GAP_CMD  = CMD_WAIT + 1;
   localparam int GAP_CLR  = CLR_WAIT + 1;

   localparam int KIND_WRITE = 0;
   localparam int KIND_CLEAR = 1;
   localparam int KIND_INIT  = 2;

   typedef struct {
      logic       rs;
      logic [7:0] db;
      int         gap;
   } busExp_t;

   typedef struct {
      int kind;
      int cyc;
   } doneExp_t;

   logic       clkLCD;
   logic       resetLCDn;
   logic [7:0] data;
   logic       writeStart;
   logic       clearStart;
   logic       initDone;
   logic       writeDone;
   logic       clearDone;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_db;

   busExp_t    busQ[$];
   doneExp_t   doneQ[$];
   int         cyc;
   int         col;
   int         errors;
   int         checks;

   lcd_char_ctrl #(
      .POWERUP_CYC  (POWERUP),
      .EN_HIGH_CYC  (EN_HIGH),
      .CMD_WAIT_CYC (CMD_WAIT),
      .CLR_WAIT_CYC (CLR_WAIT)
   ) dut (
      .clkLCD     (clkLCD),
      .resetLCDn  (resetLCDn),
      .data       (data),
      .writeStart (writeStart),
      .clearStart (clearStart),
      .initDone   (initDone),
      .writeDone  (writeDone),
      .clearDone  (clearDone),
      .lcd_e      (lcd_e),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_db     (lcd_db)
   );

   // 10 ns clock.
   initial clkLCD = 1'b0;
   always #5 clkLCD = ~clkLCD;

   // Cycle number. It names the clock period that follows each rising edge.
   initial cyc = 0;
   always @(posedge clkLCD) cyc = cyc + 1;

   // One comparison: count it, and report it if it does not match.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks = checks + 1;
      if (actual != expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic pushBus(input logic rs, input logic [7:0] db, input int gap);
      busExp_t b;
      b.rs  = rs;
      b.db  = db;
      b.gap = gap;
      busQ.push_back(b);
   endtask

   task automatic pushDone(input int kind, input int when);
      doneExp_t d;
      d.kind = kind;
      d.cyc  = when;
      doneQ.push_back(d);
   endtask

   // Pop one done event and compare its kind and its arrival cycle.
   task automatic popDone(input int kind);
      doneExp_t d;
      if (doneQ.size() == 0) begin
         checkOutput("unexpectedDone", kind, -1);
      end else begin
         d = doneQ.pop_front();
         checkOutput("doneKind", kind, d.kind);
         checkOutput("doneCycle", cyc, d.cyc);
      end
   endtask

   // Wait, with a cycle budget, until every expected event has been seen.
   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((doneQ.size() != 0 || busQ.size() != 0) && n < budget) begin
         @(posedge clkLCD);
         n = n + 1;
      end
      if (doneQ.size() != 0 || busQ.size() != 0) begin
         checkOutput("timeoutPending", doneQ.size() + busQ.size(), 0);
         doneQ.delete();
         busQ.delete();
      end
   endtask

   // Hold reset, then release it and expect the complete init sequence.
   // A write request issued in the middle of init must have no effect.
   task automatic doInit();
      int r;
      resetLCDn = 1'b0;
      repeat (3) @(posedge clkLCD);
      #1;
      resetLCDn = 1'b1;
      r = cyc;
      col = 0;
      pushBus(1'b0, 8'h38, POWERUP + 1);
      pushBus(1'b0, 8'h38, GAP_CMD);
      pushBus(1'b0, 8'h0C, GAP_CMD);
      pushBus(1'b0, 8'h01, GAP_CMD);
      pushBus(1'b0, 8'h06, GAP_CLR);
      pushDone(KIND_INIT, r + POWERUP + 4 * (1 + EN_HIGH + CMD_WAIT) + (1 + EN_HIGH + CLR_WAIT));
      repeat (30) @(posedge clkLCD);
      #1;
      writeStart = 1'b1;
      data = 8'h77;
      @(posedge clkLCD);
      #1;
      writeStart = 1'b0;
      waitIdle(400);
   endtask

   // Issue one request and record the expected bus writes and done event.
   // When poke is set, the same write is requested again while the first
   // is busy. That second request must be ignored, and lcd_db/lcd_rs must
   // still carry the first character. Use poke only when no address
   // command is expected.
   task automatic applyStimulus(input logic w, input logic c, input logic [7:0] d, input bit poke);
      int n;
      @(posedge clkLCD);
      #1;
      writeStart = w;
      clearStart = c;
      data = d;
      n = cyc;
      if (w) begin
         if (col == 0 || col == 16) begin
            pushBus(1'b0, (col == 16) ? 8'hC0 : 8'h80, -1);
            pushBus(1'b1, d, GAP_CMD);
            pushDone(KIND_WRITE, n + LAT_ADDR);
         end else begin
            pushBus(1'b1, d, -1);
            pushDone(KIND_WRITE, n + LAT);
         end
         col = (col + 1) % 32;
      end else if (c) begin
         pushBus(1'b0, 8'h01, -1);
         pushDone(KIND_CLEAR, n + LAT_CLR);
         col = 0;
      end
      @(posedge clkLCD);
      #1;
      writeStart = 1'b0;
      clearStart = 1'b0;
      if (poke) begin
         @(posedge clkLCD);
         @(posedge clkLCD);
         #1;
         writeStart = 1'b1;
         data = 8'h55;
         @(posedge clkLCD);
         #1;
         writeStart = 1'b0;
         @(posedge clkLCD);
         @(posedge clkLCD);
         #1;
         checkOutput("busyDbHeld", lcd_db, d);
         checkOutput("busyRsHeld", lcd_rs, 1);
      end
      waitIdle(200);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      col = 0;
      resetLCDn = 1'b0;
      data = 8'h00;
      writeStart = 1'b0;
      clearStart = 1'b0;

      fork
         // Monitor: compare what the DUT shows against the scoreboard.
         begin : monitor
            logic prevE;
            logic prevInit;
            int   hiCnt;
            int   loCnt;
            busExp_t b;
            prevE = 1'b0;
            prevInit = 1'b0;
            hiCnt = 0;
            loCnt = 0;
            forever begin
               @(negedge clkLCD);
               if (!resetLCDn) begin
                  prevE = 1'b0;
                  prevInit = 1'b0;
                  hiCnt = 0;
                  loCnt = 0;
               end else begin
                  if (lcd_e && !prevE) begin
                     if (busQ.size() == 0) begin
                        checkOutput("unexpectedBusWrite", {23'd0, lcd_rs, lcd_db}, -1);
                     end else begin
                        b = busQ.pop_front();
                        checkOutput("busRs", lcd_rs, b.rs);
                        checkOutput("busDb", lcd_db, b.db);
                        checkOutput("busRw", lcd_rw, 0);
                        if (b.gap >= 0) begin
                           checkOutput("busLowGap", loCnt, b.gap);
                        end
                     end
                     hiCnt = 1;
                  end else if (lcd_e) begin
                     hiCnt = hiCnt + 1;
                  end else if (prevE) begin
                     checkOutput("enHighLen", hiCnt, EN_HIGH);
                     loCnt = 1;
                  end else begin
                     loCnt = loCnt + 1;
                  end
                  prevE = lcd_e;

                  if (writeDone) popDone(KIND_WRITE);
                  if (clearDone) popDone(KIND_CLEAR);
                  if (initDone && !prevInit) popDone(KIND_INIT);
                  if (!initDone && prevInit) checkOutput("initDoneDropped", 0, 1);
                  prevInit = initDone;
               end
            end
         end

         // Stimulus
         begin : stimulus
            // Reset state.
            repeat (2) @(posedge clkLCD);
            #1;
            checkOutput("rstLcdE", lcd_e, 0);
            checkOutput("rstLcdRs", lcd_rs, 0);
            checkOutput("rstLcdRw", lcd_rw, 0);
            checkOutput("rstLcdDb", lcd_db, 0);
            checkOutput("rstInitDone", initDone, 0);
            checkOutput("rstWriteDone", writeDone, 0);
            checkOutput("rstClearDone", clearDone, 0);

            // Power-up wait and init sequence, with a request during init.
            doInit();
            checkOutput("initDoneHigh", initDone, 1);

            // First write right after init goes through 0x80.
            applyStimulus(1'b1, 1'b0, 8'h49, 1'b0);
            // Second write, with an ignored request while busy.
            applyStimulus(1'b1, 1'b0, 8'h4A, 1'b1);

            // Clear, then 33 writes to exercise both line wraps.
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            for (int i = 0; i < 33; i++) begin
               if (i < 16)       applyStimulus(1'b1, 1'b0, 8'h41, 1'b0);
               else if (i == 16) applyStimulus(1'b1, 1'b0, 8'h42, 1'b0);
               else if (i < 32)  applyStimulus(1'b1, 1'b0, 8'h43, 1'b0);
               else              applyStimulus(1'b1, 1'b0, 8'h44, 1'b0);
            end

            // A write and a clear in the same cycle: only the write is served.
            applyStimulus(1'b1, 1'b1, 8'h21, 1'b0);
            // A later clear on its own.
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

            // Reset in the EN_HI phase of a write, then a full re-init.
            @(posedge clkLCD);
            #1;
            writeStart = 1'b1;
            data = 8'h5A;
            @(posedge clkLCD);
            #1;
            writeStart = 1'b0;
            @(posedge clkLCD);
            #1;
            resetLCDn = 1'b0;
            #1;
            checkOutput("abortLcdE", lcd_e, 0);
            checkOutput("abortWriteDone", writeDone, 0);
            checkOutput("abortInitDone", initDone, 0);
            busQ.delete();
            doneQ.delete();
            doInit();
            checkOutput("reinitDoneHigh", initDone, 1);

            // Drain a few cycles so any stray pulse is seen by the monitor.
            repeat (30) @(posedge clkLCD);
            #1;
            checkOutput("finalBusQEmpty", busQ.size(), 0);
            checkOutput("finalDoneQEmpty", doneQ.size(), 0);

            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      join_any
   end

endmodule
